control_encoder: RTL and testbench

- Transmit-side counterpart of the accelerator's control decoder.
- Accepts high-level commands over a valid/ready interface and checks them against the decoder's legality rules.
- Buffers legal commands in a small FIFO and serializes them as packed {encoded_control, data_control} words over a valid/ready link to the decoder.
- Sits between the sequencer/host command path and the decoder; illegal commands never reach the link.

---
 rtl/control_encoder.sv | 167 ++++++++++++++++
 tb/tb_control_encoder.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/control_encoder.sv
// control_encoder: checks host commands against the decoder's legality rules,
// buffers legal ones in a small FIFO and serializes them as packed
// {encoded_control, data_control} words over a valid/ready link.
module control_encoder #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned ISSUE_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_unit_id,
  input  logic [1:0]             cmd_op,
  input  logic [1:0]             cmd_comp,
  input  logic [3:0]             cmd_addr,
  input  logic                   cmd_dvalid,
  input  logic [2:0]             cmd_size,
  input  logic                   flush,
  input  logic                   err_clear,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic [5:0]             encoded_control,
  output logic [7:0]             data_control,
  output logic                   reject_pulse,
  output logic [1:0]             err_status,
  output logic [ISSUE_CNT_W-1:0] issued_cnt,
  output logic [7:0]             reject_cnt
);

  localparam int unsigned WORD_W = 14;
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_COMP = 2'b11;

  typedef enum logic {
    ST_EMPTY  = 1'b0,
    ST_LOADED = 1'b1
  } state_t;

  state_t             state;
  logic [WORD_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;

  logic               accept_c;
  logic               nop_err_c;
  logic               comp_err_c;
  logic               illegal_c;
  logic               push_c;
  logic               pop_c;
  logic               fifo_empty_c;
  logic [CNT_W-1:0]   count_next_c;
  logic [WORD_W-1:0]  cmd_word_c;

  // Handshake, legality and FIFO push/pop decisions for this cycle
  always_comb begin
    accept_c     = cmd_valid && cmd_ready;
    nop_err_c    = (cmd_op == OP_NOP) &&
                   ((cmd_addr != 4'd0) || cmd_dvalid || (cmd_size != 3'd0));
    comp_err_c   = (cmd_op == OP_COMP) && !cmd_dvalid;
    illegal_c    = nop_err_c || comp_err_c;
    push_c       = accept_c && !illegal_c && !flush;
    fifo_empty_c = (count == CNT_W'(0));
    pop_c        = !flush && !fifo_empty_c &&
                   ((state == ST_EMPTY) || tx_ready);
    count_next_c = flush ? CNT_W'(0)
                         : CNT_W'(count + CNT_W'(push_c) - CNT_W'(pop_c));
    cmd_word_c   = {cmd_unit_id, cmd_op, cmd_comp, cmd_addr, cmd_dvalid, cmd_size};
  end

  // FIFO storage; entries need no reset since occupancy qualifies them
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= cmd_word_c;
    end
  end

  // FIFO pointers, occupancy and the registered ready (full -> not ready)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      cmd_ready <= 1'b0;
    end else begin
      count     <= count_next_c;
      cmd_ready <= (count_next_c != CNT_W'(DEPTH));
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_c) begin
          wr_ptr <= PTR_W'(wr_ptr + PTR_W'(1));
        end
        if (pop_c) begin
          rd_ptr <= PTR_W'(rd_ptr + PTR_W'(1));
        end
      end
    end
  end

  // Output stage: words are held while stalled and kept (unqualified) when empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_EMPTY;
      tx_valid        <= 1'b0;
      encoded_control <= '0;
      data_control    <= '0;
    end else if (flush) begin
      state    <= ST_EMPTY;
      tx_valid <= 1'b0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (pop_c) begin
            state                           <= ST_LOADED;
            tx_valid                        <= 1'b1;
            {encoded_control, data_control} <= mem[rd_ptr];
          end
        end
        ST_LOADED: begin
          if (tx_ready) begin
            if (pop_c) begin
              {encoded_control, data_control} <= mem[rd_ptr];
            end else begin
              state    <= ST_EMPTY;
              tx_valid <= 1'b0;
            end
          end
        end
        default: begin
          state    <= ST_EMPTY;
          tx_valid <= 1'b0;
        end
      endcase
    end
  end

  // Transfer counter (wraps) counts completed link handshakes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_cnt <= '0;
    end else if (tx_valid && tx_ready) begin
      issued_cnt <= ISSUE_CNT_W'(issued_cnt + ISSUE_CNT_W'(1));
    end
  end

  // Reject pulse, saturating reject counter and sticky error bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reject_pulse <= 1'b0;
      reject_cnt   <= '0;
      err_status   <= '0;
    end else begin
      reject_pulse <= accept_c && illegal_c && !flush;
      if (accept_c && illegal_c && !flush && (reject_cnt != 8'hFF)) begin
        reject_cnt <= 8'(reject_cnt + 8'd1);
      end
      err_status <= (err_clear ? 2'b00 : err_status) |
                    ((accept_c && !flush) ? {comp_err_c, nop_err_c} : 2'b00);
    end
  end

endmodule

// File: tb/tb_control_encoder.sv
// Self-checking bench for control_encoder: a scoreboard queue of expected link
// words plus a small reference model of counters and error flags.
`timescale 1ns/1ps
module tb_control_encoder;

  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_unit_id;
  logic [1:0]       cmd_op;
  logic [1:0]       cmd_comp;
  logic [3:0]       cmd_addr;
  logic             cmd_dvalid;
  logic [2:0]       cmd_size;
  logic             flush;
  logic             err_clear;
  logic             tx_valid;
  logic             tx_ready;
  logic [5:0]       encoded_control;
  logic [7:0]       data_control;
  logic             reject_pulse;
  logic [1:0]       err_status;
  logic [CNT_W-1:0] issued_cnt;
  logic [7:0]       reject_cnt;

  control_encoder #(.DEPTH(4), .ISSUE_CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_unit_id(cmd_unit_id), .cmd_op(cmd_op), .cmd_comp(cmd_comp),
    .cmd_addr(cmd_addr), .cmd_dvalid(cmd_dvalid), .cmd_size(cmd_size),
    .flush(flush), .err_clear(err_clear),
    .tx_valid(tx_valid), .tx_ready(tx_ready),
    .encoded_control(encoded_control), .data_control(data_control),
    .reject_pulse(reject_pulse), .err_status(err_status),
    .issued_cnt(issued_cnt), .reject_cnt(reject_cnt)
  );

  always #5 clk = ~clk;

  int unsigned total_cnt = 0;
  int unsigned pass_cnt  = 0;

  // Model state
  logic [13:0] exp_q[$];
  logic        exp_pulse;
  int unsigned exp_rej;
  int unsigned exp_iss;
  logic [1:0]  exp_err;
  int unsigned hs_cnt  = 0;
  int unsigned cur_run = 0;
  int unsigned max_run = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
  endtask

  // Scoreboard and reference model, evaluated away from the active edge
  always @(negedge clk) begin
    logic [13:0] w;
    logic        n_err;
    logic        c_err;
    if (!rst_n) begin
      exp_q.delete();
      exp_pulse = 1'b0;
      exp_rej   = 0;
      exp_iss   = 0;
      exp_err   = 2'b00;
      cur_run   = 0;
    end else begin
      check_eq("reject_pulse", 32'(reject_pulse), 32'(exp_pulse));
      check_eq("reject_cnt",   32'(reject_cnt),   32'(exp_rej));
      check_eq("issued_cnt",   32'(issued_cnt),   32'(exp_iss % (1 << CNT_W)));
      check_eq("err_status",   32'(err_status),   32'(exp_err));
      exp_pulse = 1'b0;
      if (tx_valid && tx_ready) begin
        hs_cnt++;
        cur_run++;
        if (cur_run > max_run) max_run = cur_run;
        exp_iss++;
        if (exp_q.size() == 0) begin
          check_eq("tx_word_unexpected", 32'({encoded_control, data_control}), 32'hFFFF_FFFF);
        end else begin
          w = exp_q.pop_front();
          check_eq("tx_word", 32'({encoded_control, data_control}), 32'(w));
        end
      end else begin
        cur_run = 0;
      end
      if (flush) exp_q.delete();
      n_err = (cmd_op == 2'b00) && ((cmd_addr != 0) || cmd_dvalid || (cmd_size != 0));
      c_err = (cmd_op == 2'b11) && !cmd_dvalid;
      if (err_clear) exp_err = 2'b00;
      if (cmd_valid && cmd_ready && !flush) begin
        if (n_err || c_err) begin
          exp_err   = exp_err | {c_err, n_err};
          exp_pulse = 1'b1;
          if (exp_rej < 255) exp_rej++;
        end else begin
          exp_q.push_back({cmd_unit_id, cmd_op, cmd_comp, cmd_addr, cmd_dvalid, cmd_size});
        end
      end
    end
  end

  // Present one command and hold it until the accepting edge (bounded)
  task automatic send(input logic [1:0] u, input logic [1:0] op, input logic [1:0] cp,
                      input logic [3:0] a, input logic dv, input logic [2:0] sz);
    logic ok;
    logic done;
    done = 1'b0;
    cmd_unit_id = u; cmd_op = op; cmd_comp = cp;
    cmd_addr = a; cmd_dvalid = dv; cmd_size = sz;
    cmd_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      ok = cmd_ready;
      @(posedge clk);
      if (ok) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check_eq("send_timeout", 32'd0, 32'd1);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [13:0] hold_w;
  int unsigned hs0;

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_unit_id = '0; cmd_op = '0; cmd_comp = '0;
    cmd_addr = '0; cmd_dvalid = 1'b0; cmd_size = '0; flush = 1'b0; err_clear = 1'b0;
    tx_ready = 1'b1;
    #1;
    check_eq("rst_tx_valid", 32'(tx_valid), 32'd0);
    check_eq("rst_words", 32'({encoded_control, data_control}), 32'd0);
    check_eq("rst_counters", 32'({issued_cnt, reject_cnt, err_status, reject_pulse}), 32'd0);
    #21;
    rst_n = 1'b1;
    #1;
    check_eq("ready_before_edge", 32'(cmd_ready), 32'd0);
    step(1);
    check_eq("ready_after_edge", 32'(cmd_ready), 32'd1);

    // Legal LOAD with 2-edge fill latency
    send(2'd2, 2'b01, 2'b00, 4'd5, 1'b1, 3'd3);
    check_eq("load_not_yet_valid", 32'(tx_valid), 32'd0);
    step(1);
    check_eq("load_tx_valid", 32'(tx_valid), 32'd1);
    check_eq("load_encoded", 32'(encoded_control), 32'h24);
    check_eq("load_data", 32'(data_control), 32'h5B);
    step(2);
    check_eq("load_issued", 32'(issued_cnt), 32'd1);

    // Illegal commands and sticky errors
    send(2'd0, 2'b00, 2'b00, 4'd0, 1'b0, 3'd1);
    check_eq("nop_reject_pulse", 32'(reject_pulse), 32'd1);
    step(1);
    check_eq("nop_pulse_gone", 32'(reject_pulse), 32'd0);
    check_eq("nop_err", 32'(err_status), 32'b01);
    check_eq("nop_rej_cnt", 32'(reject_cnt), 32'd1);
    check_eq("nop_not_sent", 32'(tx_valid), 32'd0);
    send(2'd1, 2'b11, 2'b01, 4'd3, 1'b0, 3'd2);
    step(1);
    check_eq("comp_err", 32'(err_status), 32'b11);
    err_clear = 1'b1;
    step(1);
    err_clear = 1'b0;
    check_eq("err_cleared", 32'(err_status), 32'b00);

    // Backpressure: 4 FIFO entries plus the output stage
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      send(2'(i), 2'b10, 2'(i + 1), 4'(i + 8), 1'b1, 3'(i));
    check_eq("bp_ready_low", 32'(cmd_ready), 32'd0);
    hold_w = {encoded_control, data_control};
    step(3);
    check_eq("bp_word_stable", 32'({encoded_control, data_control}), 32'(hold_w));
    check_eq("bp_valid_held", 32'(tx_valid), 32'd1);
    tx_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_drain_valid", 32'(tx_valid), 32'd1);
      step(1);
    end
    check_eq("bp_drained", 32'(tx_valid), 32'd0);
    check_eq("bp_ready_back", 32'(cmd_ready), 32'd1);

    // Throughput: 20 back-to-back words
    step(1);
    hs0 = hs_cnt;
    max_run = 0;
    for (int i = 0; i < 20; i++)
      send(2'(i), (i % 2 == 0) ? 2'b01 : 2'b11, 2'(i), 4'(i), 1'b1, 3'(i));
    step(4);
    check_eq("tp_count", 32'(hs_cnt - hs0), 32'd20);
    check_eq("tp_run", 32'(max_run), 32'd20);
    check_eq("tp_issued_wrap", 32'(issued_cnt), 32'd10);

    // Flush mid-stall with 3 queued words, plus a command in the flush cycle
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      send(2'd3, 2'b01, 2'b10, 4'(i + 1), 1'b0, 3'd7);
    check_eq("fl_valid_before", 32'(tx_valid), 32'd1);
    flush = 1'b1;
    send(2'd1, 2'b10, 2'b00, 4'd9, 1'b1, 3'd1);
    flush = 1'b0;
    check_eq("fl_tx_valid", 32'(tx_valid), 32'd0);
    check_eq("fl_ready", 32'(cmd_ready), 32'd1);
    check_eq("fl_issued", 32'(issued_cnt), 32'd10);
    check_eq("fl_reject", 32'(reject_cnt), 32'd2);
    hs0 = hs_cnt;
    tx_ready = 1'b1;
    step(4);
    check_eq("fl_nothing_sent", 32'(hs_cnt - hs0), 32'd0);

    // Saturation of the reject counter
    for (int i = 0; i < 300; i++) begin
      if (i % 2 == 0) send(2'(i), 2'b00, 2'b00, 4'd1, 1'b0, 3'd0);
      else            send(2'(i), 2'b11, 2'b10, 4'd0, 1'b0, 3'd0);
    end
    check_eq("rej_saturated", 32'(reject_cnt), 32'd255);
    step(1);
    check_eq("rej_err_both", 32'(err_status), 32'b11);

    // Async reset mid-stream
    tx_ready = 1'b0;
    send(2'd2, 2'b01, 2'b11, 4'hF, 1'b1, 3'd5);
    send(2'd1, 2'b10, 2'b01, 4'hA, 1'b1, 3'd6);
    step(1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_tx_valid", 32'(tx_valid), 32'd0);
    check_eq("arst_words", 32'({encoded_control, data_control}), 32'd0);
    check_eq("arst_counters", 32'({issued_cnt, reject_cnt, err_status, reject_pulse}), 32'd0);
    check_eq("arst_ready", 32'(cmd_ready), 32'd0);
    #10;
    rst_n = 1'b1;
    tx_ready = 1'b1;
    step(3);
    check_eq("post_rst_idle", 32'(tx_valid), 32'd0);
    check_eq("post_rst_ready", 32'(cmd_ready), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
